seq_mult_div: RTL

SEQ_MULT_DIV -- requirements
Module: seq_mult_div

---
 rtl/seq_mult_div_pkg.sv | 26 ++
 rtl/seq_mult_div_sign_mag_conv.sv | 19 +
 rtl/seq_mult_div.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_div_pkg.sv
// Shared definitions for the sequential signed multiply/divide unit.
//   cmd_e      : encodings of the 2-bit ctrl command input
//   state_e    : FSM state encoding
//   ITER_COUNT : number of single-bit iteration steps per operation
package seq_mult_div_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned ITER_COUNT = 32;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_MULT = 2'b01,
    CMD_DIV  = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULT = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/seq_mult_div_sign_mag_conv.sv
// sign_mag_conv: combinational conditional two's-complement negate.
//   val_in  : 32-bit input value
//   neg_in  : when high, output is -val_in; otherwise val_in
//   val_out : result
// With neg_in tied to val_in[31] this yields the magnitude (0x80000000
// maps to itself, which is the correct unsigned magnitude 2^31).
module sign_mag_conv
  import seq_mult_div_pkg::*;
(
  input  logic [DATA_W-1:0] val_in,
  input  logic              neg_in,
  output logic [DATA_W-1:0] val_out
);

  always_comb begin
    val_out = neg_in ? (~val_in + DATA_W'(1)) : val_in;
  end

endmodule

// File: rtl/seq_mult_div.sv
// seq_mult_div: iterative 32x32 signed multiplier (radix-2 Booth) and
// signed restoring divider, one step per clock, 32 steps per operation.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   a_in     : multiplicand / dividend (two's complement)
//   b_in     : multiplier / divisor (two's complement)
//   ctrl     : 00 none, 01 multiply, 10 divide, 11 treated as none
//   hi_out   : product[63:32] or remainder
//   lo_out   : product[31:0]  or quotient
//   busy     : high while a multiply or divide is iterating
//   done     : one-cycle pulse when an operation finishes
//   div_zero : one-cycle pulse (with done) for a divide by zero
module seq_mult_div
  import seq_mult_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [1:0]        ctrl,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Shared working register: {acc, mq, q1} is the Booth register for
  // multiply; for divide acc is the partial remainder, mq the dividend
  // shifting out / quotient shifting in.
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]  mq_q, mq_d;
  logic               q1_q, q1_d;
  logic [DATA_W-1:0]  opb_q, opb_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic               dz_q, dz_d;

  cmd_e               cmd;
  logic [DATA_W-1:0]  a_mag, b_mag;
  logic [DATA_W:0]    booth_sum;
  logic [DATA_W:0]    div_shift;
  logic [DATA_W-1:0]  rem_n, quo_n;
  logic [DATA_W-1:0]  rem_fix, quo_fix;

  assign cmd = cmd_e'(ctrl);

  sign_mag_conv u_abs_a (.val_in(a_in),  .neg_in(a_in[DATA_W-1]), .val_out(a_mag));
  sign_mag_conv u_abs_b (.val_in(b_in),  .neg_in(b_in[DATA_W-1]), .val_out(b_mag));
  sign_mag_conv u_fix_q (.val_in(quo_n), .neg_in(q_neg_q),        .val_out(quo_fix));
  sign_mag_conv u_fix_r (.val_in(rem_n), .neg_in(r_neg_q),        .val_out(rem_fix));

  // Booth add/subtract is done at 33 bits so that subtracting a
  // multiplicand of -2^31 cannot overflow; the shift then drops bit 0
  // into mq, keeping the stored register at 65 bits.
  always_comb begin
    booth_sum = {acc_q[DATA_W-1], acc_q};
    unique case ({mq_q[0], q1_q})
      2'b01:   booth_sum = {acc_q[DATA_W-1], acc_q} + {opb_q[DATA_W-1], opb_q};
      2'b10:   booth_sum = {acc_q[DATA_W-1], acc_q} - {opb_q[DATA_W-1], opb_q};
      default: booth_sum = {acc_q[DATA_W-1], acc_q};
    endcase
  end

  // Restoring division step on magnitudes; the remainder is always below
  // the divisor (<= 2^31), so the 33-bit shifted value cannot overflow.
  always_comb begin
    div_shift = {acc_q, mq_q[DATA_W-1]};
    rem_n     = div_shift[DATA_W-1:0];
    quo_n     = {mq_q[DATA_W-2:0], 1'b0};
    if (div_shift >= {1'b0, opb_q}) begin
      rem_n = DATA_W'(div_shift - {1'b0, opb_q});
      quo_n = {mq_q[DATA_W-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    q1_d    = q1_q;
    opb_d   = opb_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;

    unique case (state_q)
      ST_IDLE: begin
        dz_d = 1'b0;
        if (cmd == CMD_MULT) begin
          acc_d   = '0;
          mq_d    = b_in;
          q1_d    = 1'b0;
          opb_d   = a_in;
          cnt_d   = '0;
          state_d = ST_MULT;
        end else if (cmd == CMD_DIV) begin
          cnt_d = '0;
          if (b_in == '0) begin
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d   = '0;
            mq_d    = a_mag;
            opb_d   = b_mag;
            q_neg_d = a_in[DATA_W-1] ^ b_in[DATA_W-1];
            r_neg_d = a_in[DATA_W-1];
            state_d = ST_DIV;
          end
        end
      end
      ST_MULT: begin
        acc_d = booth_sum[DATA_W:1];
        mq_d  = {booth_sum[0], mq_q[DATA_W-1:1]};
        q1_d  = mq_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          hi_d    = booth_sum[DATA_W:1];
          lo_d    = {booth_sum[0], mq_q[DATA_W-1:1]};
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        acc_d = rem_n;
        mq_d  = quo_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          hi_d    = rem_fix;
          lo_d    = quo_fix;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        dz_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      q1_q    <= 1'b0;
      opb_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      q1_q    <= q1_d;
      opb_q   <= opb_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state_q == ST_MULT) || (state_q == ST_DIV);
  assign done     = (state_q == ST_DONE);
  assign div_zero = dz_q;

endmodule
